sync_ts_collector: RTL

- Runs the per-port two-way sync exchange and gathers the four 16-bit timestamps (t0 request tx, t1 peer rx, t2 peer tx, t3 response rx) for each of NUM_PORTS ports.
- Sits directly upstream of the local timer correction stage and drives its update_time_valid / update_time inputs.
- Paces requests, matches responses by sequence number, applies timeout and round-trip sanity filtering, and discards exchanges disturbed by a timer correction.

---
 rtl/sync_ts_pkg.sv | 38 +++
 rtl/sync_ts_collector_port.sv | 117 +++++++++++
 rtl/sync_ts_collector.sv | 82 ++++++++
 3 files changed

// File: rtl/sync_ts_pkg.sv
// Shared types and constants for the two-way sync timestamp collector.
// Holds the per-port FSM state encoding, timestamp/sequence/record widths,
// the field offsets of t0..t3 inside a 64-bit record and the record packer.
package sync_ts_pkg;

    localparam int TS_W  = 16;
    localparam int SEQ_W = 8;
    localparam int REC_W = 64;

    // Record layout {t0,t1,t2,t3}: t0 in the top bits, t3 in the bottom.
    localparam int T0_OFF = 48;
    localparam int T1_OFF = 32;
    localparam int T2_OFF = 16;
    localparam int T3_OFF = 0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TX   = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_EMIT      = 2'd3
    } port_state_t;

    function automatic logic [REC_W-1:0] pack_rec(
        input logic [TS_W-1:0] t0,
        input logic [TS_W-1:0] t1,
        input logic [TS_W-1:0] t2,
        input logic [TS_W-1:0] t3
    );
        logic [REC_W-1:0] rec;
        rec = '0;
        rec[T0_OFF +: TS_W] = t0;
        rec[T1_OFF +: TS_W] = t1;
        rec[T2_OFF +: TS_W] = t2;
        rec[T3_OFF +: TS_W] = t3;
        return rec;
    endfunction

endpackage

// File: rtl/sync_ts_collector_port.sv
// Per-port two-way sync exchange engine.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   local_time      local time base, sampled for t0 and t3
//   corr_any        a timer correction was applied this cycle
//   tx_done         request left the tx datapath (t0 capture)
//   resp_valid/seq/ts  parsed response; ts = {t1,t2}
//   sync_req, seq   request pulse and its sequence number
//   upd_valid, upd_rec  record strobe and held record {t0,t1,t2,t3}
//   drop            1-cycle strobe when an exchange is discarded
module sync_port_fsm
    import sync_ts_pkg::*;
#(
    parameter logic [15:0] SYNC_PERIOD = 16'd50000,
    parameter logic [15:0] TIMEOUT_CYC = 16'd8192,
    parameter logic [15:0] MAX_RTT     = 16'd4096,
    parameter logic [15:0] STAGGER     = 16'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TS_W-1:0]    local_time,
    input  logic               corr_any,
    input  logic               tx_done,
    input  logic               resp_valid,
    input  logic [SEQ_W-1:0]   resp_seq,
    input  logic [2*TS_W-1:0]  resp_ts,
    output logic               sync_req,
    output logic [SEQ_W-1:0]   seq,
    output logic               upd_valid,
    output logic [REC_W-1:0]   upd_rec,
    output logic               drop
);

    port_state_t     state;
    logic [15:0]     period_cnt;
    logic [15:0]     tout_cnt;
    logic            stale;
    logic [TS_W-1:0] t0, t1, t2, t3;
    logic [TS_W-1:0] rtt;
    logic            tick;

    assign tick = (period_cnt == SYNC_PERIOD - 16'd1);
    // Round trip minus peer residence, wrapping arithmetic on 16 bits.
    assign rtt  = (t3 - t0) - (t2 - t1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            period_cnt <= STAGGER;
            tout_cnt   <= '0;
            seq        <= '0;
            stale      <= 1'b0;
            t0         <= '0;
            t1         <= '0;
            t2         <= '0;
            t3         <= '0;
            sync_req   <= 1'b0;
            upd_valid  <= 1'b0;
            upd_rec    <= '0;
            drop       <= 1'b0;
        end else begin
            sync_req   <= 1'b0;
            upd_valid  <= 1'b0;
            drop       <= 1'b0;
            period_cnt <= tick ? 16'd0 : period_cnt + 16'd1;

            // t0 and t3 would straddle a time jump: poison this exchange.
            if (corr_any && (state == ST_WAIT_TX || state == ST_WAIT_RESP))
                stale <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        sync_req <= 1'b1;
                        stale    <= 1'b0;
                        state    <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (tx_done) begin
                        t0       <= local_time;
                        tout_cnt <= '0;
                        state    <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    // A match wins over a timeout landing in the same cycle.
                    if (resp_valid && resp_seq == seq) begin
                        t1    <= resp_ts[2*TS_W-1:TS_W];
                        t2    <= resp_ts[TS_W-1:0];
                        t3    <= local_time;
                        state <= ST_EMIT;
                    end else if (tout_cnt == TIMEOUT_CYC) begin
                        // Advance seq so a late reply to this request cannot match.
                        drop  <= 1'b1;
                        seq   <= seq + 8'd1;
                        state <= ST_IDLE;
                    end else begin
                        tout_cnt <= tout_cnt + 16'd1;
                    end
                end
                ST_EMIT: begin
                    if (!stale && rtt <= MAX_RTT) begin
                        upd_valid <= 1'b1;
                        upd_rec   <= pack_rec(t0, t1, t2, t3);
                    end else begin
                        drop <= 1'b1;
                    end
                    seq   <= seq + 8'd1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sync_ts_collector.sv
// Collects {t0,t1,t2,t3} sync timestamps for NUM_PORTS ports and feeds the
// timer correction stage. One sync_port_fsm per port; a shared saturating
// counter tallies discarded exchanges across all ports.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   local_time          free-running local time
//   corr_valid_i        correction strobes (any bit = time jumped)
//   sync_req_o/seq_o    per-port request pulse and sequence number
//   tx_done_i           per-port request sent
//   rx_resp_*_i         per-port response valid, seq, {t1,t2}
//   update_time_valid   per-port record strobe
//   update_time         per-port record {t0,t1,t2,t3}
//   drop_cnt_o          saturating discarded-exchange count
module sync_ts_collector
    import sync_ts_pkg::*;
#(
    parameter int          NUM_PORTS   = 4,
    parameter logic [15:0] SYNC_PERIOD = 16'd50000,
    parameter logic [15:0] TIMEOUT_CYC = 16'd8192,
    parameter logic [15:0] MAX_RTT     = 16'd4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [TS_W-1:0]             local_time,
    input  logic [NUM_PORTS-1:0]        corr_valid_i,
    output logic [NUM_PORTS-1:0]        sync_req_o,
    output logic [SEQ_W*NUM_PORTS-1:0]  sync_seq_o,
    input  logic [NUM_PORTS-1:0]        tx_done_i,
    input  logic [NUM_PORTS-1:0]        rx_resp_valid_i,
    input  logic [SEQ_W*NUM_PORTS-1:0]  rx_resp_seq_i,
    input  logic [32*NUM_PORTS-1:0]     rx_resp_ts_i,
    output logic [NUM_PORTS-1:0]        update_time_valid,
    output logic [REC_W*NUM_PORTS-1:0]  update_time,
    output logic [15:0]                 drop_cnt_o
);

    logic                 corr_any;
    logic [NUM_PORTS-1:0] drop_vec;
    logic [15:0]          drop_pop;
    logic [16:0]          drop_sum;

    assign corr_any = |corr_valid_i;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        sync_port_fsm #(
            .SYNC_PERIOD (SYNC_PERIOD),
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .MAX_RTT     (MAX_RTT),
            .STAGGER     (16'(i * (int'(SYNC_PERIOD) / NUM_PORTS)))
        ) u_port (
            .clk        (clk),
            .rst        (rst),
            .local_time (local_time),
            .corr_any   (corr_any),
            .tx_done    (tx_done_i[i]),
            .resp_valid (rx_resp_valid_i[i]),
            .resp_seq   (rx_resp_seq_i[i*SEQ_W +: SEQ_W]),
            .resp_ts    (rx_resp_ts_i[i*32 +: 32]),
            .sync_req   (sync_req_o[i]),
            .seq        (sync_seq_o[i*SEQ_W +: SEQ_W]),
            .upd_valid  (update_time_valid[i]),
            .upd_rec    (update_time[i*REC_W +: REC_W]),
            .drop       (drop_vec[i])
        );
    end

    always_comb begin
        drop_pop = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            drop_pop = drop_pop + 16'(drop_vec[i]);
    end

    assign drop_sum = {1'b0, drop_cnt_o} + {1'b0, drop_pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt_o <= '0;
        else
            drop_cnt_o <= drop_sum[16] ? 16'hffff : drop_sum[15:0];
    end

endmodule
